char_draw_counter: RTL and testbench
====================================

CHAR_DRAW_COUNTER -- requirements
Module: char_draw_counter

Interface
- REQ-001: Parameter CHAR_W, default 8: glyph width in pixels; legal range 2..64.
- REQ-002: Parameter CHAR_H, default 8: glyph height in pixels; legal range 2..64.
- REQ-003: Parameter MAX_CHARS, default 32: maximum characters per run; legal range 2..1024.
- REQ-004: Derived widths SHALL be XW=clog2(CHAR_W), YW=clog2(CHAR_H), CW=clog2(MAX_CHARS).
- REQ-005: Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-006: Port resetn, input, 1 bit: asynchronous, active-low reset.
- REQ-007: Port start, input, 1 bit: request a run; sampled only in IDLE.
- REQ-008: Port num_chars, input, CW+1 bits: characters to draw; sampled with start.
- REQ-009: Port ready, input, 1 bit: the downstream pixel writer accepts the current pixel.
- REQ-010: Port abort, input, 1 bit: cancel the run in progress.
- REQ-011: Port pixel_valid, output, 1 bit: x_off, y_off and char_idx present a pixel.
- REQ-012: Port x_off, output, XW bits: column within the glyph.
- REQ-013: Port y_off, output, YW bits: row within the glyph.
- REQ-014: Port char_idx, output, CW bits: index of the character being drawn.
- REQ-015: Port char_done, output, 1 bit: asserted in the cycle the last pixel of a character is accepted.
- REQ-016: Port done, output, 1 bit: one-cycle pulse at run completion.
- REQ-017: Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-018: FSM states SHALL be IDLE, DRAW and DONE, state-registered.
- REQ-019: In IDLE with start=1 and num_chars!=0, the block SHALL enter DRAW next cycle with the latched count, x_off=0, y_off=0 and char_idx=0.
- REQ-020: A num_chars value above MAX_CHARS SHALL be clamped to MAX_CHARS when latched.
- REQ-021: In IDLE with start=1 and num_chars=0, the block SHALL go to DONE without emitting any pixel.
- REQ-022: start SHALL be ignored outside IDLE, and the latched count SHALL NOT change mid-run.
- REQ-023: pixel_valid SHALL equal (state==DRAW) and SHALL NOT depend combinationally on ready.
- REQ-024: A pixel is accepted when pixel_valid=1 and ready=1; when ready=0, x_off, y_off and char_idx SHALL hold.
- REQ-025: On acceptance, x_off SHALL increment; at x_off=CHAR_W-1 it SHALL wrap to 0 and y_off SHALL increment.
- REQ-026: On acceptance at x_off=CHAR_W-1 and y_off=CHAR_H-1, y_off SHALL wrap to 0 and char_done SHALL be high in that cycle (combinational from state, counters and ready).
- REQ-027: In that same acceptance cycle, if char_idx equals the latched count minus 1, the next state SHALL be DONE; otherwise char_idx SHALL increment.
- REQ-028: DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- REQ-029: abort=1 in DRAW SHALL force IDLE next cycle with all counters cleared, no done pulse and no char_done in that cycle.
- REQ-030: abort=1 in IDLE or DONE SHALL have no effect.
- REQ-031: abort SHALL take priority over pixel acceptance in the same cycle.
- REQ-032: With ready held at 1, a run of N characters SHALL take N*CHAR_W*CHAR_H DRAW cycles plus one DONE cycle.

Reset
- REQ-033: While resetn=0, the block SHALL be in IDLE with x_off=0, y_off=0, char_idx=0, the latched count=0, and pixel_valid=0, char_done=0, done=0, busy=0, independent of clock.
- REQ-034: Reset asserted mid-run SHALL abandon the run immediately, with no done pulse.
- REQ-035: After deassertion, the block SHALL accept start on the first rising edge.

Verification
- REQ-036: Defaults, num_chars=1, ready=1, start pulsed at cycle 0 -> pixel_valid high in cycles 1..64; char_done at cycle 64 (x=7, y=7); done at cycle 65; busy high in cycles 1..65.
- REQ-037: num_chars=3, ready=1 -> char_idx runs 0,1,2; char_done at cycles 64, 128 and 192; done at cycle 193.
- REQ-038: ready toggled 1,0 every cycle, num_chars=1 -> offsets hold during ready=0; done at cycle 129; the pixel sequence is identical to REQ-036.
- REQ-039: abort at the 10th DRAW cycle -> IDLE next cycle, counters 0, no done; a following start restarts from char_idx=0.
- REQ-040: num_chars=0 with start -> done at cycle 1 and pixel_valid never high; num_chars=40 with MAX_CHARS=32 -> the final char_idx is 31.
- REQ-041: resetn pulsed low asynchronously mid-character -> all outputs 0 immediately, with no done pulse.

Source files
------------

// File: rtl/char_draw_counter.sv
// Walks glyph pixels (x, then y, then character) for a run of num_chars glyphs.
// Latency: first pixel one cycle after start; done one cycle after the last accepted pixel.
// Backpressure: ready=0 holds all offsets; pixel_valid never depends on ready.
module char_draw_counter #(
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 8,
  parameter int MAX_CHARS = 32,
  localparam int XW = $clog2(CHAR_W),
  localparam int YW = $clog2(CHAR_H),
  localparam int CW = $clog2(MAX_CHARS)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [CW:0]   num_chars,
  input  logic          ready,
  input  logic          abort,
  output logic          pixel_valid,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic [CW-1:0] char_idx,
  output logic          char_done,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state, state_nxt;
  logic [CW:0] count;
  logic [CW:0] count_clamped;
  logic        x_last, y_last, last_char, accept;

  assign x_last        = (x_off == XW'(CHAR_W - 1));
  assign y_last        = (y_off == YW'(CHAR_H - 1));
  assign last_char     = ({1'b0, char_idx} == (count - (CW+1)'(1)));
  // abort outranks acceptance, so an aborted cycle never advances or flags char_done
  assign accept        = (state == DRAW) && ready && !abort;
  assign count_clamped = (num_chars > (CW+1)'(MAX_CHARS)) ? (CW+1)'(MAX_CHARS) : num_chars;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (num_chars == '0) ? DONE : DRAW;
      DRAW: begin
        if (abort)                                   state_nxt = IDLE;
        else if (accept && x_last && y_last && last_char) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pixel_valid = (state == DRAW);
    busy        = (state != IDLE);
    done        = (state == DONE);
    char_done   = accept && x_last && y_last;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_off    <= '0;
      y_off    <= '0;
      char_idx <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          x_off    <= '0;
          y_off    <= '0;
          char_idx <= '0;
          if (start) count <= count_clamped;
        end
        DRAW: begin
          if (abort) begin
            x_off    <= '0;
            y_off    <= '0;
            char_idx <= '0;
            count    <= '0;
          end else if (accept) begin
            x_off <= x_last ? '0 : x_off + XW'(1);
            if (x_last) y_off <= y_last ? '0 : y_off + YW'(1);
            if (x_last && y_last && !last_char) char_idx <= char_idx + CW'(1);
          end
        end
        default: begin
          x_off    <= '0;
          y_off    <= '0;
          char_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_draw_counter.sv
// Directed bench for char_draw_counter at default parameters (8x8 glyphs, 32 chars max).
module tb_char_draw_counter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [5:0] num_chars;
  logic       ready;
  logic       abort;
  logic       pixel_valid;
  logic [2:0] x_off;
  logic [2:0] y_off;
  logic [4:0] char_idx;
  logic       char_done;
  logic       done;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  char_draw_counter dut (
    .clock(clock), .resetn(resetn), .start(start), .num_chars(num_chars),
    .ready(ready), .abort(abort), .pixel_valid(pixel_valid), .x_off(x_off),
    .y_off(y_off), .char_idx(char_idx), .char_done(char_done), .done(done), .busy(busy)
  );

  task automatic test_reset();
    n_cmp++;
    if ({pixel_valid, x_off, y_off, char_idx, char_done, done, busy} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b x=%0d y=%0d ci=%0d cd=%b d=%b b=%b want all 0",
               pixel_valid, x_off, y_off, char_idx, char_done, done, busy);
    end
  endtask

  // Full run with a pixel-by-pixel model; toggle=1 drives ready 0 on odd cycles.
  task automatic test_run(input int n, input bit toggle, input string name);
    int eff, total, p, done_cyc, exp_done;
    bit rdy, finished;
    eff = (n > 32) ? 32 : n;
    total = eff * 64;
    p = 0; done_cyc = -1; finished = 0;
    exp_done = toggle ? 2 * total + 1 : total + 1;
    @(posedge clock); #1;
    start = 1'b1; num_chars = n[5:0]; ready = 1'b1; abort = 1'b0;
    for (int c = 1; c < 6000 && !finished; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      ready = rdy;
      #2;
      if (p < total) begin
        n_cmp++;
        if (pixel_valid !== 1'b1 || x_off !== 3'(p % 8) || y_off !== 3'((p / 8) % 8) ||
            char_idx !== 5'(p / 64) || busy !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_pixel c=%0d got v=%b x=%0d y=%0d ci=%0d b=%b d=%b want v=1 x=%0d y=%0d ci=%0d b=1 d=0",
                   name, c, pixel_valid, x_off, y_off, char_idx, busy, done, p % 8, (p / 8) % 8, p / 64);
        end
        n_cmp++;
        if (char_done !== (rdy && (p % 64 == 63))) begin
          n_bad++;
          $display("FAIL %s_char_done c=%0d got %b want %b", name, c, char_done, rdy && (p % 64 == 63));
        end
        if (rdy) p++;
      end else if (done_cyc < 0) begin
        done_cyc = c;
        n_cmp++;
        if (pixel_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || char_done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_done_state c=%0d got v=%b d=%b b=%b cd=%b want v=0 d=1 b=1 cd=0",
                   name, c, pixel_valid, done, busy, char_done);
        end
      end else begin
        finished = 1;
        n_cmp++;
        if ({pixel_valid, x_off, y_off, char_idx, char_done, done, busy} !== 16'h0) begin
          n_bad++;
          $display("FAIL %s_idle_after c=%0d got v=%b x=%0d y=%0d ci=%0d d=%b b=%b want all 0",
                   name, c, pixel_valid, x_off, y_off, char_idx, done, busy);
        end
      end
    end
    n_cmp++;
    if (done_cyc !== exp_done) begin
      n_bad++;
      $display("FAIL %s_done_cycle got %0d want %0d", name, done_cyc, exp_done);
    end
  endtask

  task automatic test_abort(input int at);
    @(posedge clock); #1;
    start = 1'b1; num_chars = 6'd2; ready = 1'b1; abort = 1'b0;
    for (int c = 1; c <= at; c++) begin
      @(posedge clock); #1;
      start = 1'b0; abort = (c == at); #2;
    end
    n_cmp++;
    if (pixel_valid !== 1'b1 || char_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort%0d_cycle got v=%b cd=%b want v=1 cd=0", at, pixel_valid, char_done);
    end
    @(posedge clock); #1; abort = 1'b0; #2;
    n_cmp++;
    if ({pixel_valid, x_off, y_off, char_idx, char_done, done, busy} !== 16'h0) begin
      n_bad++;
      $display("FAIL abort%0d_idle got v=%b x=%0d y=%0d ci=%0d d=%b b=%b want all 0",
               at, pixel_valid, x_off, y_off, char_idx, done, busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #3;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort%0d_no_done got d=%b b=%b want 0 0", at, done, busy);
      end
    end
    @(posedge clock); #1; start = 1'b1; num_chars = 6'd1;
    @(posedge clock); #1; start = 1'b0; #2;
    n_cmp++;
    if (pixel_valid !== 1'b1 || x_off !== 3'd0 || y_off !== 3'd0 || char_idx !== 5'd0) begin
      n_bad++;
      $display("FAIL abort%0d_restart got v=%b x=%0d y=%0d ci=%0d want 1 0 0 0",
               at, pixel_valid, x_off, y_off, char_idx);
    end
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
  endtask

  // abort while IDLE must not block the start that arrives with it
  task automatic test_abort_idle();
    @(posedge clock); #1;
    start = 1'b1; num_chars = 6'd1; abort = 1'b1; ready = 1'b1;
    @(posedge clock); #1; start = 1'b0; #2;
    n_cmp++;
    if (pixel_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle_start got v=%b b=%b want 1 1", pixel_valid, busy);
    end
    @(posedge clock); #3;
    n_cmp++;
    if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle_then_draw got v=%b b=%b d=%b want 0 0 0", pixel_valid, busy, done);
    end
    #1; abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    int done_cyc;
    done_cyc = -1;
    @(posedge clock); #1;
    start = 1'b1; num_chars = 6'd1; ready = 1'b1; abort = 1'b0;
    for (int c = 1; c < 300 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      start = (c < 60); num_chars = 6'd3; #2;
      if (done === 1'b1) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc !== 65) begin
      n_bad++;
      $display("FAIL start_ignored_done_cycle got %0d want 65", done_cyc);
    end
    @(posedge clock); #3;
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    start = 1'b1; num_chars = 6'd1; ready = 1'b1; abort = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1; start = 1'b0;
    end
    #2; resetn = 1'b0; #1;
    n_cmp++;
    if ({pixel_valid, x_off, y_off, char_idx, char_done, done, busy} !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset_now got v=%b x=%0d y=%0d ci=%0d cd=%b d=%b b=%b want all 0",
               pixel_valid, x_off, y_off, char_idx, char_done, done, busy);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #3;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset_hold got d=%b b=%b want 0 0", done, busy);
      end
    end
    @(posedge clock); #1; resetn = 1'b1; start = 1'b1; num_chars = 6'd1;
    @(posedge clock); #1; start = 1'b0; #2;
    n_cmp++;
    if (pixel_valid !== 1'b1 || x_off !== 3'd0 || char_idx !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_release_start got v=%b x=%0d ci=%0d want 1 0 0", pixel_valid, x_off, char_idx);
    end
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; num_chars = '0; ready = 1'b0; abort = 1'b0;
    #3;
    test_reset();
    @(posedge clock); #1; resetn = 1'b1;
    test_run(1,  1'b0, "single");
    test_run(3,  1'b0, "multi");
    test_run(1,  1'b1, "backpressure");
    test_run(0,  1'b0, "zero");
    test_run(40, 1'b0, "clamp");
    test_abort(10);
    test_abort(64);
    test_abort_idle();
    test_start_ignored();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
